// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state type and constants for the UART TX arbiter
//   NREQ_MAX    - largest supported requester count
//   TIMEOUT_DEF - default stall limit before a granted requester is evicted
//   state_e     - arbiter FSM states
package uart_arb_pkg;
  localparam int NREQ_MAX = 8;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [1:0] {IDLE, GRANTED, SEND} state_e;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker
//   req_i  - request vector
//   last_i - index of the previous owner; search starts just above it
//   pick_o - one-hot winner, zero when no request
//   idx_o  - binary index of the winner
//   any_o  - at least one request present
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  logic [NREQ-1:0] rot;
  logic [IW-1:0]   off;
  assign any_o = |req_i;
  // Rotate so bit 0 is the requester right after last_i; the lowest set bit
  // of the rotated vector is then the round-robin winner.
  always_comb begin
    rot = NREQ'({req_i, req_i} >> (int'(last_i) + 1));
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) off = IW'(k);
    idx_o = IW'((int'(off) + int'(last_i) + 1) % NREQ);
    pick_o = any_o ? NREQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-atomic sharing of one UART transmitter
//   clock/reset          - system clock, asynchronous active-low reset
//   req_i                - per-requester link request (sampled only when idle)
//   grant_o              - one-hot current owner, zero when idle
//   src_data_i           - byte of requester i at [8i+7:8i]
//   src_valid_i/last_i   - requester byte present / byte ends the packet
//   src_ready_o          - one-cycle pulse when the owner's byte is taken
//   uart_ready_i         - UART idle and able to accept a byte
//   uart_data_o          - byte to the UART, holds the last value sent
//   uart_clock_enable_o  - UART load strobe, held until uart_ready_i falls
//   busy_o               - link owned
//   timeout_abort_o      - one-cycle pulse when a stalled owner is evicted
// Optional: define UART_ARB_TIMEOUT_EN to evict an owner after TIMEOUT
// consecutive stalled cycles; otherwise timeout_abort_o stays 0.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_i,
  output logic [NREQ-1:0]   grant_o,
  input  logic [NREQ*8-1:0] src_data_i,
  input  logic [NREQ-1:0]   src_valid_i,
  input  logic [NREQ-1:0]   src_last_i,
  output logic [NREQ-1:0]   src_ready_o,
  input  logic              uart_ready_i,
  output logic [7:0]        uart_data_o,
  output logic              uart_clock_enable_o,
  output logic              busy_o,
  output logic              timeout_abort_o
);
  localparam int IW = $clog2(NREQ);
  state_e          state_q;
  logic [NREQ-1:0] grant_q, src_ready_q, pick_d;
  logic [IW-1:0]   owner_q, last_owner_q, pick_idx_d;
  logic [7:0]      uart_data_q, own_data_d;
  logic            uce_q, last_flag_q, abort_q, any_d, own_valid_d, own_last_d;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q;
`else
  logic            unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i  (req_i),
    .last_i (last_owner_q),
    .pick_o (pick_d),
    .idx_o  (pick_idx_d),
    .any_o  (any_d)
  );

  assign own_valid_d = src_valid_i[owner_q];
  assign own_last_d  = src_last_i[owner_q];
  assign own_data_d  = 8'(src_data_i >> {owner_q, 3'b000});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IW'(NREQ - 1);
      src_ready_q  <= '0;
      uart_data_q  <= '0;
      uce_q        <= 1'b0;
      last_flag_q  <= 1'b0;
      abort_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      src_ready_q <= '0;
      abort_q     <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (any_d) begin
            grant_q <= pick_d;
            owner_q <= pick_idx_d;
            state_q <= GRANTED;
          end
        end
        GRANTED: begin
          if (own_valid_d && uart_ready_i) begin
            uart_data_q <= own_data_d;
            uce_q       <= 1'b1;
            src_ready_q <= grant_q;
            last_flag_q <= own_last_d;
            state_q     <= SEND;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
`ifdef UART_ARB_TIMEOUT_EN
          // Only an owner with nothing to send is stalled; a busy UART is not its fault.
          else if (own_valid_d) cnt_q <= '0;
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            grant_q      <= '0;
            last_owner_q <= owner_q;
            abort_q      <= 1'b1;
            state_q      <= IDLE;
          end
          else cnt_q <= cnt_q + 1'b1;
`endif
        end
        SEND: begin
          // uart_ready falling means the UART has latched the byte.
          if (!uart_ready_i) begin
            uce_q <= 1'b0;
            if (last_flag_q) begin
              grant_q      <= '0;
              last_owner_q <= owner_q;
              state_q      <= IDLE;
            end else state_q <= GRANTED;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o             = grant_q;
  assign src_ready_o         = src_ready_q;
  assign uart_data_o         = uart_data_q;
  assign uart_clock_enable_o = uce_q;
  assign busy_o              = |grant_q;
  assign timeout_abort_o     = abort_q;
endmodule
